mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares memory_wrapper_2port between two write clients and two read clients (e.g. multiplier + DMA).
// - Port B (write) and port A (read) are each round-robin arbitrated, independently.
// - Blocks a same-address read/write collision, tags each read, and returns data to the requester.
// PARAMETERS
// WIDTH       32  data width of memory words and client data
// ADDR_W      6   address width (64-entry memory)
// MEM_RD_LAT  1   cycles from accepted read (cenA low at posedge) to q valid; legal 1..4
// PORTS
// clk            in   1       single clock, all logic on posedge
// rst            in   1       synchronous reset, active-low
// EN_wr0/1       in   1       write request, client 0/1
// RDY_wr0/1      out  1       write grant; transfer on EN_wrN && RDY_wrN
// wr0/1_addr     in   ADDR_W  write address
// wr0/1_data     in   WIDTH   write data
// EN_rd0/1       in   1       read request, client 0/1
// RDY_rd0/1      out  1       read grant; accepted on EN_rdN && RDY_rdN
// rd0/1_addr     in   ADDR_W  read address
// VALID_rd0/1    out  1       read data valid for client N
// rd0/1_data     out  WIDTH   read data (= q when VALID_rdN, else 0)
// cenA, aA       out  1/ADDR_W  memory read port strobe (active-low) and address
// cenB, aB, d    out  1/ADDR_W/WIDTH  memory write port strobe (active-low), address, data
// q              in   WIDTH   memory read data
// BEHAVIOUR
// - Reset (rst==0 at posedge):
//   - all RDY_*, VALID_* = 0; cenA = cenB = 1; aA, aB, d, rd*_data = 0.
//   - Both RR pointers -> client 0; read tag pipeline flushed.
//   - A read in flight at reset is dropped and never returns VALID.
// - Grant is combinational in the request cycle; RDY asserts only if the matching EN is high.
//   - At most one RDY_wr* and one RDY_rd* high per cycle.
// - Round robin, per port: the pointer names the favoured client.
//   - Both requesting -> favoured client granted.
//   - One requesting -> that client granted, whatever the pointer says.
//   - After any grant to client k, pointer <= the other client; no grant -> pointer holds.
// - Memory drive, combinational from the granted client:
//   - write grant -> cenB=0, aB=wrN_addr, d=wrN_data; otherwise cenB=1 and aB/d hold 0.
//   - read grant -> cenA=0, aA=rdN_addr; otherwise cenA=1.
// - Collision: a granted write and a would-be read grant target the same address in the same cycle.
//   - Write proceeds.
//   - All read grants are withheld that cycle (cenA=1, RDY_rd*=0); read pointer holds.
//   - The read client retries; it reads the new data on a later cycle.
// - Read return:
//   - Each accepted read pushes {valid, client_id} into a MEM_RD_LAT-deep shift register.
//   - At the tail, VALID_rd<id>=1 for exactly one cycle and rd<id>_data = q.
//   - Back-to-back reads give one VALID per cycle, in order; no stall on the return path.
// - Read latency = MEM_RD_LAT cycles from the accept edge to VALID.
//   - Write commits at the accept edge.
//   - A read accepted one cycle after a write to the same address returns the new data.
// - Requests held with EN high and RDY low must keep address and data stable.
//   - Clients may drop EN while waiting; nothing is queued.
// CONFIGURATION
// - MARB_STATS_EN defined: adds 3 outputs, each 16 bits:
//   - stat_wr_grants, stat_rd_grants, stat_conflicts.
//   - They count accepted writes, accepted reads and collision cycles.
//   - Counters saturate at 16'hFFFF and clear to 0 on reset.
// - MARB_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
// 1. Reset:
//    - Hold rst=0 for 3 cycles with all EN high.
//    - All RDY/VALID=0, cenA=cenB=1 throughout.
//    - First grants after release go to client 0 on both ports.
// 2. Write round robin:
//    - EN_wr0=EN_wr1=1 for 4 cycles; addr 0..3 and 10..13; data = addr*addr.
//    - Grants alternate 0,1,0,1; memory holds [0]=0, [10]=100, [1]=1, [11]=121.
// 3. Single requester:
//    - Only EN_rd1 high for 5 cycles, addr 0..4.
//    - RDY_rd1=1 every cycle.
//    - VALID_rd1 on 5 consecutive cycles, first one MEM_RD_LAT cycles later.
//    - Data 0,1,4,9,16 after a write preload of squares.
// 4. Collision:
//    - Write addr 5 data 25 and read addr 5 in the same cycle.
//    - That cycle: cenA=1, RDY_rd0=0, stat_conflicts += 1.
//    - Next cycle the read is granted and returns 25.
// 5. Interleaved returns:
//    - Reads alternating clients 0/1 on addr 2,3,4,5.
//    - VALID_rd0/VALID_rd1 alternate with data 4,9,16,25; never both high.
// 6. Reset mid-read:
//    - Accept a read, then assert rst=0 before it returns.
//    - No VALID asserts for that read; the pipeline is empty after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing a 2-port memory between two writers and two readers
// Optional MARB_STATS_EN adds saturating grant/conflict counters.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 6,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN_wr0,
    input  logic              EN_wr1,
    output logic              RDY_wr0,
    output logic              RDY_wr1,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [WIDTH-1:0]  wr0_data,
    input  logic [WIDTH-1:0]  wr1_data,
    input  logic              EN_rd0,
    input  logic              EN_rd1,
    output logic              RDY_rd0,
    output logic              RDY_rd1,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              VALID_rd0,
    output logic              VALID_rd1,
    output logic [WIDTH-1:0]  rd0_data,
    output logic [WIDTH-1:0]  rd1_data,
    output logic              cenA,
    output logic [ADDR_W-1:0] aA,
    output logic              cenB,
    output logic [ADDR_W-1:0] aB,
    output logic [WIDTH-1:0]  d,
`ifdef MARB_STATS_EN
    output logic [15:0]       stat_wr_grants,
    output logic [15:0]       stat_rd_grants,
    output logic [15:0]       stat_conflicts,
`endif
    input  logic [WIDTH-1:0]  q
);

    logic wrPtr, rdPtr;
    logic wrGnt0, wrGnt1, rdPick0, rdPick1, rdGnt0, rdGnt1;
    logic wrGrant, rdGrant, conflict;
    logic [ADDR_W-1:0] wrAddr, rdAddr;
    logic [WIDTH-1:0] wrData;
    logic [MEM_RD_LAT-1:0] tagValid, tagId;
    logic tailValid, tailId;

    // Pointer value names the favoured client; a lone requester wins regardless.
    always_comb begin
        wrGnt0   = rst && EN_wr0 && (!EN_wr1 || !wrPtr);
        wrGnt1   = rst && EN_wr1 && (!EN_wr0 || wrPtr);
        rdPick0  = rst && EN_rd0 && (!EN_rd1 || !rdPtr);
        rdPick1  = rst && EN_rd1 && (!EN_rd0 || rdPtr);
        wrGrant  = wrGnt0 || wrGnt1;
        wrAddr   = wrGnt1 ? wr1_addr : wr0_addr;
        wrData   = wrGnt1 ? wr1_data : wr0_data;
        rdAddr   = rdPick1 ? rd1_addr : rd0_addr;
        conflict = wrGrant && (rdPick0 || rdPick1) && (wrAddr == rdAddr);
        rdGnt0   = rdPick0 && !conflict;
        rdGnt1   = rdPick1 && !conflict;
        rdGrant  = rdGnt0 || rdGnt1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
        end else begin
            if (wrGrant) wrPtr <= wrGnt0;
            if (rdGrant) rdPtr <= rdGnt0;
        end
    end

    // Tag shift register tracks which client owns the q word arriving MEM_RD_LAT edges later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tagValid <= '0;
            tagId    <= '0;
        end else begin
            tagValid[0] <= rdGrant;
            tagId[0]    <= rdGnt1;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagId[i]    <= tagId[i-1];
            end
        end
    end

    assign tailValid = tagValid[MEM_RD_LAT-1];
    assign tailId    = tagId[MEM_RD_LAT-1];

    always_comb begin
        RDY_wr0   = wrGnt0;
        RDY_wr1   = wrGnt1;
        RDY_rd0   = rdGnt0;
        RDY_rd1   = rdGnt1;
        cenB      = !wrGrant;
        aB        = wrGrant ? wrAddr : '0;
        d         = wrGrant ? wrData : '0;
        cenA      = !rdGrant;
        aA        = rdGrant ? rdAddr : '0;
        VALID_rd0 = rst && tailValid && !tailId;
        VALID_rd1 = rst && tailValid && tailId;
        rd0_data  = VALID_rd0 ? q : '0;
        rd1_data  = VALID_rd1 ? q : '0;
    end

`ifdef MARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_wr_grants <= '0;
            stat_rd_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (wrGrant && stat_wr_grants != 16'hFFFF) stat_wr_grants <= stat_wr_grants + 16'd1;
            if (rdGrant && stat_rd_grants != 16'hFFFF) stat_rd_grants <= stat_rd_grants + 16'd1;
            if (conflict && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule
